decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised RV32I integer-ALU instruction decoder with a valid/ready handshake on both sides and a DEPTH-entry output buffer. It decodes all R-type (opcode 0110011) and I-type ALU (opcode 0010011) instructions into register indices, an ALU operation code, a sign-extended immediate and control flags, and flags everything else as illegal. It sits between instruction fetch and the register-read/execute stage, and decouples fetch from execute back-pressure.

## Interface
- XLEN, 32: immediate output width; must be ≥ 32.
- DEPTH, 2: output buffer entries; power of two, ≥ 1.
- CNT_W, 8: width of the illegal-instruction counter.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  buffer can accept an entry; equals (count < DEPTH).
- in_instr  in  32  raw instruction word.
- out_valid  out  1  buffer head is valid.
- out_ready  in  1  consumer accepts the head.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_alu_op  out  4  operation code: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, NOP 15.
- out_imm  out  XLEN  immediate.
- out_use_imm  out  1  operand B is out_imm rather than rs2.
- out_reg_write  out  1  result is written to out_rd.
- out_illegal  out  1  instruction is not a supported ALU instruction.
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Accept when in_valid && in_ready. The decode is combinational from in_instr; the decoded record is pushed into the buffer. Pop when out_valid && out_ready.
- R-type ALU instructions decode from funct3/funct7:
  - 000/0000000 → ADD; 000/0100000 → SUB.
  - 001/0 → SLL; 010/0 → SLT; 011/0 → SLTU; 100/0 → XOR.
  - 101/0 → SRL; 101/0100000 → SRA.
  - 110/0 → OR; 111/0 → AND.
  - For R-type: use_imm = 0 and imm = 0.
- I-type ALU instructions:
  - funct3 000/010/011/100/110/111 → ADD/SLT/SLTU/XOR/OR/AND.
  - imm = sign-extension of instr[31:20] to XLEN.
  - Shifts: funct3 001 with funct7 0 → SLL; 101 with funct7 0 → SRL; 101 with funct7 0100000 → SRA. For shifts, imm = zero-extended instr[24:20].
  - For I-type: use_imm = 1 and rs2 = 0.
- Any other opcode/funct combination:
  - illegal = 1, alu_op = NOP, reg_write = 0.
  - rs1, rs2, rd, imm = 0; use_imm = 0.
- Legal instruction with rd = 0: reg_write = 0, illegal = 0.
- Illegal instructions are still enqueued. illegal_count increments on each accepted illegal instruction and saturates at 2^CNT_W−1. illegal_count is not cleared by flush, only by reset.
- Buffer:
  - FIFO ordering, with a read pointer, a write pointer, and a count of 0..DEPTH.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - No push when full, even if a pop occurs that cycle.
- Output payload (rs1…illegal) when out_valid = 0: all zero.
- flush = 1:
  - count and both pointers go to 0 next cycle.
  - A same-cycle accept or pop is ignored, and an illegal instruction offered that cycle is not counted.
  - in_ready still reflects the current count during the flush cycle.

## Timing
- Reset values:
  - out_valid = 0; in_ready = 1.
  - All payload outputs 0; illegal_count = 0.
  - count and pointers 0.
- Latency: an instruction accepted at edge N is visible on out_* after edge N (out_valid = 1 in cycle N+1) if the buffer was empty.
- Throughput is one instruction per cycle while out_ready = 1.
- in_ready and out_valid derive only from registered count; there is no combinational in→out path.
- Head payload holds stable while out_valid && !out_ready.
- rst_n assertion mid-stream: all entries are dropped immediately, outputs take reset values asynchronously, and in-flight data is lost.

## Test plan
- Reset, then push 0x002081B3 with out_ready = 1.
  - Next cycle: out_valid = 1, rs1 = 1, rs2 = 2, rd = 3, alu_op = 0, use_imm = 0, reg_write = 1, illegal = 0.
- Push 0x402081B3, then 0xFFF00293 back-to-back.
  - First output: alu_op = 1.
  - Second output: alu_op = 0, rs1 = 0, rd = 5, imm = 0xFFFFFFFF, use_imm = 1, rs2 = 0.
- Push 0x4033D313 → alu_op = 7, rs1 = 7, rd = 6, imm = 3, use_imm = 1.
- Push 0x00000000, then 0x0000006F.
  - Both outputs: illegal = 1, alu_op = 15, reg_write = 0.
  - illegal_count = 2.
  - With CNT_W = 2, six illegal pushes → illegal_count = 3.
- out_ready = 0, push 3 instructions with DEPTH = 2.
  - in_ready = 0 after the 2nd accept; the 3rd is held.
  - Then out_ready = 1: outputs appear in order and the 3rd is accepted once count < 2.
- Fill 2 entries, then assert flush together with in_valid.
  - Next cycle: out_valid = 0, count = 0, nothing from the flush-cycle push appears.
  - illegal_count is unchanged.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I integer-ALU decoder feeding a DEPTH-entry FIFO, valid/ready on both sides.
// Illegal instructions are still enqueued; a saturating counter tracks them.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic [3:0]       out_alu_op,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_use_imm,
   output logic             out_reg_write,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int REC_W = 24 + XLEN;

   localparam logic [6:0] OPC_R = 7'b0110011;
   localparam logic [6:0] OPC_I = 7'b0010011;
   localparam logic [6:0] F7_ALT = 7'b0100000;

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic             legal;
   logic [3:0]       dec_op;
   logic [XLEN-1:0]  dec_imm;
   logic             dec_use_imm;
   logic [4:0]       dec_rs1, dec_rs2, dec_rd;
   logic             dec_reg_write;
   logic [REC_W-1:0] dec_rec;

   logic [REC_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0]    count;
   logic             push, pop;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   always_comb begin
      legal       = 1'b0;
      dec_op      = 4'd15;
      dec_imm     = '0;
      dec_use_imm = 1'b0;
      if (opcode == OPC_R) begin
         if (funct7 == 7'b0) begin
            legal = 1'b1;
            case (funct3)
               3'b000:  dec_op = 4'd0;
               3'b001:  dec_op = 4'd2;
               3'b010:  dec_op = 4'd3;
               3'b011:  dec_op = 4'd4;
               3'b100:  dec_op = 4'd5;
               3'b101:  dec_op = 4'd6;
               3'b110:  dec_op = 4'd8;
               default: dec_op = 4'd9;
            endcase
         end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
            legal  = 1'b1;
            dec_op = 4'd1;
         end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
            legal  = 1'b1;
            dec_op = 4'd7;
         end
      end else if (opcode == OPC_I) begin
         legal       = 1'b1;
         dec_use_imm = 1'b1;
         dec_imm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
         case (funct3)
            3'b000: dec_op = 4'd0;
            3'b010: dec_op = 4'd3;
            3'b011: dec_op = 4'd4;
            3'b100: dec_op = 4'd5;
            3'b110: dec_op = 4'd8;
            3'b111: dec_op = 4'd9;
            3'b001: begin
               dec_imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};
               if (funct7 == 7'b0) dec_op = 4'd2;
               else                legal  = 1'b0;
            end
            default: begin
               dec_imm = {{(XLEN-5){1'b0}}, in_instr[24:20]};
               if (funct7 == 7'b0)        dec_op = 4'd6;
               else if (funct7 == F7_ALT) dec_op = 4'd7;
               else                       legal  = 1'b0;
            end
         endcase
      end
      // Illegal encodings collapse to an all-zero NOP payload.
      if (!legal) begin
         dec_op      = 4'd15;
         dec_imm     = '0;
         dec_use_imm = 1'b0;
      end
   end

   assign dec_rs1       = legal ? in_instr[19:15] : 5'd0;
   assign dec_rs2       = (legal && opcode == OPC_R) ? in_instr[24:20] : 5'd0;
   assign dec_rd        = legal ? in_instr[11:7] : 5'd0;
   assign dec_reg_write = legal && (in_instr[11:7] != 5'd0);
   assign dec_rec = {dec_rs1, dec_rs2, dec_rd, dec_op, dec_imm,
                     dec_use_imm, dec_reg_write, !legal};

   assign in_ready  = (count < CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= dec_rec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         illegal_count <= '0;
      else if (push && !legal && illegal_count != {CNT_W{1'b1}})
         illegal_count <= illegal_count + 1'b1;
   end

   assign {out_rs1, out_rs2, out_rd, out_alu_op, out_imm,
           out_use_imm, out_reg_write, out_illegal} = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode values, FIFO back-pressure, flush,
// illegal counter saturation (second instance with CNT_W = 2) and async reset.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_instr;

   logic        in_ready, out_valid, out_use_imm, out_reg_write, out_illegal;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [3:0]  out_alu_op;
   logic [31:0] out_imm;
   logic [7:0]  illegal_count;

   logic        s_in_ready, s_out_valid, s_use_imm, s_reg_write, s_illegal;
   logic [4:0]  s_rs1, s_rs2, s_rd;
   logic [3:0]  s_alu_op;
   logic [31:0] s_imm;
   logic [1:0]  s_illegal_count;

   int n_compared   = 0;
   int n_mismatched = 0;

   decode_stage #(.XLEN(32), .DEPTH(2), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_alu_op(out_alu_op), .out_imm(out_imm), .out_use_imm(out_use_imm),
      .out_reg_write(out_reg_write), .out_illegal(out_illegal),
      .illegal_count(illegal_count)
   );

   decode_stage #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_rs1(s_rs1), .out_rs2(s_rs2), .out_rd(s_rd),
      .out_alu_op(s_alu_op), .out_imm(s_imm), .out_use_imm(s_use_imm),
      .out_reg_write(s_reg_write), .out_illegal(s_illegal),
      .illegal_count(s_illegal_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_compared++;
      assert (observed === expected)
      else begin
         n_mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_payload(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [3:0] op, input logic [31:0] imm,
                                input logic use_imm, input logic reg_write, input logic illegal);
      check({tag, ".valid"}, 64'(out_valid), 64'd1);
      check({tag, ".rs1"}, 64'(out_rs1), 64'(rs1));
      check({tag, ".rs2"}, 64'(out_rs2), 64'(rs2));
      check({tag, ".rd"}, 64'(out_rd), 64'(rd));
      check({tag, ".op"}, 64'(out_alu_op), 64'(op));
      check({tag, ".imm"}, 64'(out_imm), 64'(imm));
      check({tag, ".use_imm"}, 64'(out_use_imm), 64'(use_imm));
      check({tag, ".reg_write"}, 64'(out_reg_write), 64'(reg_write));
      check({tag, ".illegal"}, 64'(out_illegal), 64'(illegal));
   endtask

   task automatic check_empty(input string tag);
      check({tag, ".valid"}, 64'(out_valid), 64'd0);
      check({tag, ".payload"},
            64'({out_rs1, out_rs2, out_rd, out_alu_op, out_imm, out_use_imm, out_reg_write, out_illegal}),
            64'd0);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_empty("reset");
      check("reset.in_ready", 64'(in_ready), 64'd1);
      check("reset.cnt", 64'(illegal_count), 64'd0);
      rst_n = 1'b1;
      step();

      // add x3, x1, x2
      in_valid = 1'b1; in_instr = 32'h002081B3;
      step();
      in_valid = 1'b0;
      check_payload("add", 5'd1, 5'd2, 5'd3, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      step();
      check_empty("add.drain");

      // sub then addi x5, x0, -1 back to back
      in_valid = 1'b1; in_instr = 32'h402081B3;
      step();
      in_instr = 32'hFFF00293;
      check_payload("sub", 5'd1, 5'd2, 5'd3, 4'd1, 32'h0, 1'b0, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      check_payload("addi", 5'd0, 5'd0, 5'd5, 4'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);
      step();
      check_empty("addi.drain");

      // srai x6, x7, 3
      in_valid = 1'b1; in_instr = 32'h4033D313;
      step();
      in_valid = 1'b0;
      check_payload("srai", 5'd7, 5'd0, 5'd6, 4'd7, 32'h3, 1'b1, 1'b1, 1'b0);
      step();

      // two illegal words
      in_valid = 1'b1; in_instr = 32'h00000000;
      step();
      in_instr = 32'h0000006F;
      check_payload("ill0", 5'd0, 5'd0, 5'd0, 4'd15, 32'h0, 1'b0, 1'b0, 1'b1);
      step();
      in_valid = 1'b0;
      check_payload("ill1", 5'd0, 5'd0, 5'd0, 4'd15, 32'h0, 1'b0, 1'b0, 1'b1);
      check("ill.cnt", 64'(illegal_count), 64'd2);
      step();
      check_empty("ill.drain");

      // back-pressure: three pushes into a two-entry buffer
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h002081B3;
      step();
      check("bp.ready1", 64'(in_ready), 64'd1);
      in_instr = 32'h402081B3;
      step();
      check("bp.ready2", 64'(in_ready), 64'd0);
      in_instr = 32'h4033D313;
      step();
      check("bp.held_ready", 64'(in_ready), 64'd0);
      check_payload("bp.head_stable", 5'd1, 5'd2, 5'd3, 4'd0, 32'h0, 1'b0, 1'b1, 1'b0);
      out_ready = 1'b1;
      step();
      check_payload("bp.second", 5'd1, 5'd2, 5'd3, 4'd1, 32'h0, 1'b0, 1'b1, 1'b0);
      check("bp.ready_after_pop", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check_payload("bp.third", 5'd7, 5'd0, 5'd6, 4'd7, 32'h3, 1'b1, 1'b1, 1'b0);
      step();
      check_empty("bp.drain");

      // flush with a full buffer and an offered push
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h002081B3;
      step();
      in_instr = 32'h402081B3;
      step();
      flush = 1'b1; in_instr = 32'h00000000;
      check("flush.ready_during", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      check_empty("flush.full");
      check("flush.ready_after", 64'(in_ready), 64'd1);
      check("flush.cnt_full", 64'(illegal_count), 64'd2);

      // flush while an illegal push would otherwise be accepted
      in_valid = 1'b1; in_instr = 32'h002081B3;
      step();
      flush = 1'b1; in_instr = 32'h00000000; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check_empty("flush.partial");
      check("flush.cnt_partial", 64'(illegal_count), 64'd2);

      // six more illegal pushes: narrow counter saturates at 3
      check("sat.before", 64'(s_illegal_count), 64'd2);
      in_valid = 1'b1; in_instr = 32'h0000006F;
      for (int i = 0; i < 6; i++) step();
      in_valid = 1'b0;
      check("sat.narrow", 64'(s_illegal_count), 64'd3);
      check("sat.wide", 64'(illegal_count), 64'd8);
      step();

      // asynchronous reset mid-stream
      in_valid = 1'b1; in_instr = 32'h002081B3; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      check("areset.before", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_empty("areset");
      check("areset.cnt", 64'(illegal_count), 64'd0);
      check("areset.ready", 64'(in_ready), 64'd1);
      step();
      rst_n = 1'b1;
      step();
      check_empty("areset.after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
